// File: rtl/multi_clock_enable_gen.sv
// Multi-channel clock-enable generator: per-channel tick strobe and square-wave level,
// with run-time divisor reload that commits only on a period boundary.

module mce_ch #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DEF_DIV = WIDTH'(2)
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic             sync_clr,
    input  logic             ld_hit,
    input  logic [WIDTH-1:0] load_div,
    output logic             tick,
    output logic             level
);
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_act;
    logic [WIDTH-1:0] r_pend;
    logic             r_pflag;
    logic             w_wrap;
    logic             w_commit;

    assign w_wrap   = (r_cnt == r_act - WIDTH'(1));
    // Pending divisor lands on a wrap or while idle, so the running period never shortens.
    assign w_commit = r_pflag & (~en | w_wrap);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_act   <= DEF_DIV;
            r_pend  <= DEF_DIV;
            r_pflag <= 1'b0;
        end else if (sync_clr) begin
            r_cnt   <= '0;
            r_act   <= ld_hit ? load_div : r_pend;
            r_pend  <= ld_hit ? load_div : r_pend;
            r_pflag <= 1'b0;
        end else begin
            r_cnt <= (en && !w_wrap) ? r_cnt + WIDTH'(1) : '0;
            if (w_commit)
                r_act <= r_pend;
            // A load on the commit edge stays pending for the next boundary.
            if (ld_hit) begin
                r_pend  <= load_div;
                r_pflag <= 1'b1;
            end else if (w_commit) begin
                r_pflag <= 1'b0;
            end
        end
    end

    assign tick  = en & w_wrap;
    assign level = en & (r_cnt >= (r_act >> 1));
endmodule

module multi_clock_enable_gen #(
    parameter int                      NUM_CH       = 3,
    parameter int                      WIDTH        = 32,
    parameter logic [NUM_CH*WIDTH-1:0] DEFAULT_DIVS = {32'd1000000, 32'd204000, 32'd100000000}
) (
    input  logic                                        clk_in,
    input  logic                                        reset,
    input  logic [NUM_CH-1:0]                           en,
    input  logic                                        sync_clr,
    input  logic                                        load_valid,
    input  logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] load_ch,
    input  logic [WIDTH-1:0]                            load_div,
    output logic                                        load_err,
    output logic [NUM_CH-1:0]                           tick,
    output logic [NUM_CH-1:0]                           level
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              w_ch_ok;
    logic              w_accept;
    logic [NUM_CH-1:0] w_hit;
    logic              r_err;

    // Power-of-two channel counts cannot address a missing channel.
    generate
        if (NUM_CH == (1 << CH_W)) begin : g_ch_full
            assign w_ch_ok = 1'b1;
        end else begin : g_ch_part
            assign w_ch_ok = (load_ch < CH_W'(NUM_CH));
        end
    endgenerate

    assign w_accept = load_valid & w_ch_ok & (load_div >= WIDTH'(2));

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)
            r_err <= 1'b0;
        else
            r_err <= load_valid & ~w_accept;
    end

    assign load_err = r_err;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            assign w_hit[g] = w_accept & (load_ch == CH_W'(g));

            mce_ch #(
                .WIDTH   (WIDTH),
                .DEF_DIV (DEFAULT_DIVS[g*WIDTH +: WIDTH])
            ) u_ch (
                .clk_in   (clk_in),
                .reset    (reset),
                .en       (en[g]),
                .sync_clr (sync_clr),
                .ld_hit   (w_hit[g]),
                .load_div (load_div),
                .tick     (tick[g]),
                .level    (level[g])
            );
        end
    endgenerate
endmodule

// File: tb/tb_multi_clock_enable_gen.sv
// Bench for multi_clock_enable_gen: table-driven free run plus load, reject, sync,
// enable and async-reset sequences; expectations are queued per cycle and checked at negedge.

module tb_multi_clock_enable_gen;
    logic       clk_in = 1'b0;
    logic       reset  = 1'b1;
    logic [1:0] en     = 2'b11;
    logic       sync_clr = 1'b0;
    logic       load_valid = 1'b0;
    logic [0:0] load_ch = '0;
    logic [7:0] load_div = '0;
    logic       load_err;
    logic [1:0] tick, level;

    logic [2:0] en3 = 3'b111;
    logic       sync3 = 1'b0;
    logic       load_valid3 = 1'b0;
    logic [1:0] load_ch3 = '0;
    logic [7:0] load_div3 = '0;
    logic       load_err3;
    logic [2:0] tick3, level3;

    multi_clock_enable_gen #(.NUM_CH(2), .WIDTH(8), .DEFAULT_DIVS({8'd5, 8'd4})) u_dut (
        .clk_in(clk_in), .reset(reset), .en(en), .sync_clr(sync_clr),
        .load_valid(load_valid), .load_ch(load_ch), .load_div(load_div),
        .load_err(load_err), .tick(tick), .level(level));

    multi_clock_enable_gen #(.NUM_CH(3), .WIDTH(8), .DEFAULT_DIVS({8'd6, 8'd5, 8'd4})) u_dut3 (
        .clk_in(clk_in), .reset(reset), .en(en3), .sync_clr(sync3),
        .load_valid(load_valid3), .load_ch(load_ch3), .load_div(load_div3),
        .load_err(load_err3), .tick(tick3), .level(level3));

    always #5 clk_in = ~clk_in;

    typedef struct {
        string      nm;
        logic [1:0] tick;
        logic [1:0] level;
        logic       err;
    } exp_t;

    typedef struct {
        logic [1:0] en;
        exp_t       e;
    } vec_t;

    exp_t q[$];
    exp_t m_e;
    vec_t tbl[20];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // Expected outputs from each channel's phase within its period.
    function automatic exp_t mk(input string nm, input int p0, input int d0,
                                input int p1, input int d1, input logic [1:0] e,
                                input logic err);
        exp_t r;
        r.nm       = nm;
        r.tick[0]  = e[0] && (p0 % d0 == d0 - 1);
        r.level[0] = e[0] && (p0 % d0 >= d0 / 2);
        r.tick[1]  = e[1] && (p1 % d1 == d1 - 1);
        r.level[1] = e[1] && (p1 % d1 >= d1 / 2);
        r.err      = err;
        return r;
    endfunction

    always @(negedge clk_in) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            chk({m_e.nm, ".tick"},  32'(tick),     32'(m_e.tick));
            chk({m_e.nm, ".level"}, 32'(level),    32'(m_e.level));
            chk({m_e.nm, ".err"},   32'(load_err), 32'(m_e.err));
        end
    end

    task automatic cyc(input exp_t e);
        q.push_back(e);
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 2'b11; sync_clr = 1'b0;
        load_valid = 1'b0; load_ch = '0; load_div = '0; load_valid3 = 1'b0;
        cyc(mk("rst_a", 0, 4, 0, 5, 2'b00, 1'b0));
        cyc(mk("rst_b", 0, 4, 0, 5, 2'b00, 1'b0));
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        for (int c = 0; c < 20; c++) begin
            tbl[c].en = 2'b11;
            tbl[c].e  = mk($sformatf("free%0d", c), c, 4, c, 5, 2'b11, 1'b0);
        end

        @(posedge clk_in); #1;
        do_reset();
        foreach (tbl[i]) begin
            en = tbl[i].en;
            cyc(tbl[i].e);
        end

        // Reload ch0 to 6 while cnt=1 of its second period: ticks 3,7 then 13,19.
        do_reset();
        for (int c = 0; c < 21; c++) begin
            load_valid = (c == 5); load_ch = 1'b0; load_div = 8'd6;
            cyc(mk($sformatf("ld%0d", c), (c < 8) ? c : c - 8, (c < 8) ? 4 : 6,
                   c, 5, 2'b11, 1'b0));
        end
        load_valid = 1'b0;

        // Rejected divisors pulse load_err; an accepted load does not.
        do_reset();
        for (int c = 0; c < 10; c++) begin
            load_valid = (c == 1 || c == 3 || c == 6);
            load_ch    = (c == 6) ? 1'b1 : 1'b0;
            load_div   = (c == 1) ? 8'd1 : (c == 3) ? 8'd0 : 8'd5;
            cyc(mk($sformatf("rej%0d", c), c, 4, c, 5, 2'b11, (c == 2 || c == 4)));
        end
        load_valid = 1'b0;

        // Out-of-range channel on the three-channel instance.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            load_valid3 = (c == 1 || c == 3);
            load_ch3    = (c == 1) ? 2'd3 : 2'd2;
            load_div3   = (c == 1) ? 8'd9 : 8'd6;
            #3;
            chk($sformatf("ch3err%0d", c), 32'(load_err3), 32'(c == 2));
            chk($sformatf("ch3tick%0d", c), 32'(tick3),
                32'({c % 6 == 5, c % 5 == 4, c % 4 == 3}));
            chk($sformatf("ch3lvl%0d", c), 32'(level3),
                32'({c % 6 >= 3, c % 5 >= 2, c % 4 >= 2}));
            @(posedge clk_in); #1;
        end
        load_valid3 = 1'b0;

        // sync_clr realigns both channels; common tick 20 cycles after the pulse.
        do_reset();
        for (int c = 0; c < 6; c++)
            cyc(mk($sformatf("pre_sync%0d", c), c, 4, c, 5, 2'b11, 1'b0));
        sync_clr = 1'b1;
        cyc(mk("sync_cyc", 6, 4, 6, 5, 2'b11, 1'b0));
        sync_clr = 1'b0;
        for (int j = 0; j < 21; j++)
            cyc(mk($sformatf("post_sync%0d", j), j, 4, j, 5, 2'b11, 1'b0));
        sync_clr = 1'b1; load_valid = 1'b1; load_ch = 1'b1; load_div = 8'd3;
        cyc(mk("sync_ld", 21, 4, 21, 5, 2'b11, 1'b0));
        sync_clr = 1'b0; load_valid = 1'b0;
        for (int k = 0; k < 12; k++)
            cyc(mk($sformatf("sync_d3_%0d", k), k, 4, k, 3, 2'b11, 1'b0));

        // Drop en[1] mid-period (cycles 3..6); first tick1 D cycles after re-enable.
        do_reset();
        for (int c = 0; c < 18; c++) begin
            en = {!(c >= 3 && c <= 6), 1'b1};
            cyc(mk($sformatf("en%0d", c), c, 4, (c < 3) ? c : (c < 7) ? 0 : c - 7, 5,
                   en, 1'b0));
        end
        en = 2'b11;

        // Async reset between edges with loads pending on both channels.
        do_reset();
        cyc(mk("arst0", 0, 4, 0, 5, 2'b11, 1'b0));
        load_valid = 1'b1; load_ch = 1'b0; load_div = 8'd7;
        cyc(mk("arst1", 1, 4, 1, 5, 2'b11, 1'b0));
        load_ch = 1'b1; load_div = 8'd9;
        cyc(mk("arst2", 2, 4, 2, 5, 2'b11, 1'b0));
        load_valid = 1'b0;
        #1;
        chk("arst_pre_tick",  32'(tick),  32'(2'b01));
        chk("arst_pre_level", 32'(level), 32'(2'b11));
        #1;
        reset = 1'b1;
        #1;
        chk("arst_tick",  32'(tick),     32'd0);
        chk("arst_level", 32'(level),    32'd0);
        chk("arst_err",   32'(load_err), 32'd0);
        @(posedge clk_in); #1;
        @(posedge clk_in); #1;
        reset = 1'b0;
        foreach (tbl[i]) begin
            en = tbl[i].en;
            cyc(tbl[i].e);
        end

        @(posedge clk_in); #1;
        chk("sb_drain", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
